// File: rtl/slowlink_arbiter.sv
// Round-robin arbiter for two requesters feeding a hold register that a slow, asynchronous Bclk
// domain samples. Bclk is treated purely as data; hold_data only moves on a synchronized Bclk rise.
module slowlink_arbiter #(
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT     = 255
) (
    input  logic       Aclk,
    input  logic       reset,
    input  logic       Bclk,
    input  logic [1:0] req,
    input  logic [3:0] data0,
    input  logic [3:0] data1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [3:0] hold_data,
    output logic       hold_valid,
    output logic       hold_src,
    output logic [7:0] xfer_count,
    output logic       stall
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   bclk_s;
    logic                   bclk_p;
    logic                   bclk_rise;

    logic                   load;
    logic                   finish;
    logic                   release_hold;
    logic                   wait_enter;
    logic                   counting;

    logic                   prio;
    logic                   winner;
    logic [CNT_W-1:0]       wait_cnt;

    always_ff @(posedge Aclk) begin
        if (reset) begin
            sync_q <= '0;
            bclk_p <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Bclk};
            bclk_p <= bclk_s;
        end
    end

    assign bclk_s    = sync_q[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_p;

    always_ff @(posedge Aclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A done-only exit needs no separate state: HOLD either reloads in place or falls back to IDLE.
    always_comb begin
        state_next   = state;
        load         = 1'b0;
        finish       = 1'b0;
        release_hold = 1'b0;
        wait_enter   = 1'b0;
        counting     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    state_next = WAIT;
                    wait_enter = 1'b1;
                end
            end
            WAIT: begin
                if (bclk_rise) begin
                    if (req != 2'b00) begin
                        load       = 1'b1;
                        state_next = HOLD;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    counting = 1'b1;
                end
            end
            HOLD: begin
                if (bclk_rise) begin
                    finish = 1'b1;
                    if (req != 2'b00) begin
                        load = 1'b1;
                    end else begin
                        release_hold = 1'b1;
                        state_next   = IDLE;
                    end
                end else begin
                    counting = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // prio names the requester that wins a tie; it always points away from the last grant.
    always_comb begin
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = prio;
        end else if (req == 2'b10) begin
            winner = 1'b1;
        end
    end

    always_ff @(posedge Aclk) begin
        if (reset) begin
            gnt        <= 2'b00;
            done       <= 2'b00;
            hold_data  <= 4'h0;
            hold_valid <= 1'b0;
            hold_src   <= 1'b0;
            xfer_count <= 8'h00;
            prio       <= 1'b0;
        end else begin
            gnt  <= load ? (2'b01 << winner) : 2'b00;
            done <= finish ? (2'b01 << hold_src) : 2'b00;
            if (finish) begin
                xfer_count <= xfer_count + 8'd1;
            end
            if (load) begin
                hold_data  <= winner ? data1 : data0;
                hold_src   <= winner;
                hold_valid <= 1'b1;
                prio       <= ~winner;
            end else if (release_hold) begin
                hold_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge Aclk) begin
        if (reset) begin
            wait_cnt <= '0;
            stall    <= 1'b0;
        end else begin
            if (bclk_rise || wait_enter) begin
                wait_cnt <= '0;
            end else if (counting) begin
                if (wait_cnt != CNT_MAX) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                if (wait_cnt >= CNT_STALL) begin
                    stall <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_slowlink_arbiter.sv
// Directed and randomized bench for slowlink_arbiter, checked every Aclk cycle against a
// transfer-level reference model; Bclk is generated on Aclk falling edges.
module tb_slowlink_arbiter;

    localparam int SYNC_STAGES = 3;
    localparam int TIMEOUT     = 255;

    logic       Aclk = 1'b0;
    logic       reset;
    logic       Bclk;
    logic [1:0] req;
    logic [3:0] data0;
    logic [3:0] data1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [3:0] hold_data;
    logic       hold_valid;
    logic       hold_src;
    logic [7:0] xfer_count;
    logic       stall;

    int compared   = 0;
    int mismatched = 0;

    slowlink_arbiter #(
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .Aclk      (Aclk),
        .reset     (reset),
        .Bclk      (Bclk),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .gnt       (gnt),
        .done      (done),
        .hold_data (hold_data),
        .hold_valid(hold_valid),
        .hold_src  (hold_src),
        .xfer_count(xfer_count),
        .stall     (stall)
    );

    always #5 Aclk = ~Aclk;

    typedef enum int {M_IDLE, M_WAITING, M_HOLDING} phase_t;

    phase_t     m_phase;
    logic [3:0] m_hold_data;
    logic       m_hold_valid;
    logic       m_hold_src;
    int         m_count;
    logic       m_stall;
    int         m_waited;
    int         m_favour;
    logic [1:0] m_gnt;
    logic [1:0] m_done;
    bit         b_hist[$];
    int         done_total = 0;

    int         bclk_half   = 4;
    int         bclk_cnt    = 0;
    logic [1:0] keep_req    = 2'b00;
    bit         random_mode = 1'b0;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_phase      = M_IDLE;
        m_hold_data  = 4'h0;
        m_hold_valid = 1'b0;
        m_hold_src   = 1'b0;
        m_count      = 0;
        m_stall      = 1'b0;
        m_waited     = 0;
        m_favour     = 0;
        m_gnt        = 2'b00;
        m_done       = 2'b00;
        b_hist       = {};
        repeat (SYNC_STAGES + 1) b_hist.push_back(1'b0);
    endtask

    task automatic model_load();
        int win;
        if (req == 2'b11) begin
            win = m_favour;
        end else begin
            win = req[1] ? 1 : 0;
        end
        m_hold_data  = (win == 1) ? data1 : data0;
        m_hold_src   = (win == 1);
        m_hold_valid = 1'b1;
        m_gnt        = (win == 1) ? 2'b10 : 2'b01;
        m_favour     = 1 - win;
    endtask

    task automatic count_wait();
        m_waited++;
        if (m_waited >= TIMEOUT) m_stall = 1'b1;
    endtask

    // A Bclk level sampled at edge n is seen as a rise by the edge SYNC_STAGES later.
    task automatic model_edge();
        bit rise;
        rise = b_hist[b_hist.size() - SYNC_STAGES] && !b_hist[b_hist.size() - SYNC_STAGES - 1];
        if (reset) begin
            model_reset();
            return;
        end
        b_hist.push_back(Bclk);
        void'(b_hist.pop_front());
        m_gnt  = 2'b00;
        m_done = 2'b00;
        case (m_phase)
            M_IDLE: begin
                if (req != 2'b00) begin
                    m_phase  = M_WAITING;
                    m_waited = 0;
                end
            end
            M_WAITING: begin
                if (rise) begin
                    m_waited = 0;
                    if (req != 2'b00) begin
                        model_load();
                        m_phase = M_HOLDING;
                    end else begin
                        m_phase = M_IDLE;
                    end
                end else begin
                    count_wait();
                end
            end
            M_HOLDING: begin
                if (rise) begin
                    m_waited = 0;
                    m_done   = m_hold_src ? 2'b10 : 2'b01;
                    m_count  = (m_count + 1) % 256;
                    done_total++;
                    if (req != 2'b00) begin
                        model_load();
                    end else begin
                        m_hold_valid = 1'b0;
                        m_phase      = M_IDLE;
                    end
                end else begin
                    count_wait();
                end
            end
            default: m_phase = M_IDLE;
        endcase
    endtask

    task automatic check_output();
        check("gnt",        8'(gnt),        8'(m_gnt));
        check("done",       8'(done),       8'(m_done));
        check("hold_data",  8'(hold_data),  8'(m_hold_data));
        check("hold_valid", 8'(hold_valid), 8'(m_hold_valid));
        check("hold_src",   8'(hold_src),   8'(m_hold_src));
        check("xfer_count", xfer_count,     8'(m_count));
        check("stall",      8'(stall),      8'(m_stall));
    endtask

    task automatic apply_stimulus();
        if (bclk_half > 0) begin
            bclk_cnt++;
            if (bclk_cnt >= bclk_half) begin
                bclk_cnt = 0;
                Bclk     = ~Bclk;
                if (random_mode && !Bclk) bclk_half = $urandom_range(4, 12);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (m_gnt[i] && !keep_req[i]) req[i] = 1'b0;
        end
        if (random_mode) begin
            for (int i = 0; i < 2; i++) begin
                if (!req[i] && $urandom_range(0, 15) == 0) begin
                    if (i == 0) data0 = 4'($urandom);
                    else        data1 = 4'($urandom);
                    req[i] = 1'b1;
                end else if (req[i] && !m_gnt[i] && $urandom_range(0, 199) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge Aclk);
        model_edge();
        @(negedge Aclk);
        check_output();
        apply_stimulus();
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] gseq[$];
        logic [3:0] dseq[$];
        logic [3:0] prev_hold;
        int         grants;
        int         drops;
        int         stray;
        int         base;
        int         guard;

        reset = 1'b1;
        Bclk  = 1'b0;
        req   = 2'b00;
        data0 = 4'h0;
        data1 = 4'h0;
        model_reset();

        $display("[TB] reset state");
        do_reset(3);
        check("reset_hold_valid", 8'(hold_valid), 8'd0);
        check("reset_xfer_count", xfer_count, 8'd0);

        $display("[TB] single transfer");
        data0 = 4'hA;
        req   = 2'b01;
        base  = done_total;
        for (guard = 0; guard < 200 && done_total == base; guard++) tick();
        check("single_xfer_count", xfer_count, 8'd1);
        check("single_hold_data", 8'(hold_data), 8'hA);
        check("single_hold_valid", 8'(hold_valid), 8'd0);

        $display("[TB] contention");
        do_reset(2);
        data0    = 4'h3;
        data1    = 4'hC;
        req      = 2'b11;
        keep_req = 2'b11;
        for (guard = 0; guard < 300 && gseq.size() < 3; guard++) begin
            tick();
            if (gnt != 2'b00) begin
                gseq.push_back(gnt);
                dseq.push_back(hold_data);
            end
        end
        check("contention_grants", 8'(gseq.size()), 8'd3);
        if (gseq.size() >= 3) begin
            check("contention_gnt0", 8'(gseq[0]), 8'h1);
            check("contention_gnt1", 8'(gseq[1]), 8'h2);
            check("contention_gnt2", 8'(gseq[2]), 8'h1);
            check("contention_data0", 8'(dseq[0]), 8'h3);
            check("contention_data1", 8'(dseq[1]), 8'hC);
            check("contention_data2", 8'(dseq[2]), 8'h3);
        end
        keep_req = 2'b00;
        req      = 2'b00;
        repeat (40) tick();

        $display("[TB] back-to-back");
        do_reset(2);
        data0     = 4'h6;
        req       = 2'b01;
        keep_req  = 2'b01;
        grants    = 0;
        drops     = 0;
        stray     = 0;
        prev_hold = hold_data;
        for (guard = 0; guard < 400 && grants < 4; guard++) begin
            tick();
            if (gnt != 2'b00) begin
                grants++;
                data0 = data0 + 4'h3;
            end else begin
                if (hold_data !== prev_hold) stray++;
                if (grants > 0 && !hold_valid) drops++;
            end
            prev_hold = hold_data;
        end
        check("b2b_grants", 8'(grants), 8'd4);
        check("b2b_valid_drops", 8'(drops), 8'd0);
        check("b2b_stray_changes", 8'(stray), 8'd0);
        keep_req = 2'b00;
        req      = 2'b00;
        repeat (40) tick();

        $display("[TB] stall");
        bclk_half = 0;
        Bclk      = 1'b0;
        do_reset(2);
        data0 = 4'h9;
        req   = 2'b01;
        repeat (300) tick();
        check("stall_set", 8'(stall), 8'd1);
        check("stall_no_grant", 8'(hold_valid), 8'd0);
        bclk_half = 4;
        bclk_cnt  = 0;
        base      = done_total;
        for (guard = 0; guard < 200 && done_total == base; guard++) tick();
        check("stall_sticky", 8'(stall), 8'd1);
        check("stall_xfer_count", xfer_count, 8'd1);

        $display("[TB] reset during hold");
        do_reset(2);
        data0 = 4'h5;
        req   = 2'b01;
        for (guard = 0; guard < 200 && m_phase != M_HOLDING; guard++) tick();
        repeat (2) tick();
        check("midhold_data", 8'(hold_data), 8'h5);
        check("midhold_valid", 8'(hold_valid), 8'd1);
        do_reset(1);
        check("midhold_reset_data", 8'(hold_data), 8'd0);
        check("midhold_reset_valid", 8'(hold_valid), 8'd0);
        check("midhold_reset_done", 8'(done), 8'd0);
        base = done_total;
        repeat (40) tick();
        check("midhold_no_done", 8'(done_total - base), 8'd0);

        $display("[TB] xfer_count wrap");
        do_reset(2);
        data0    = 4'h7;
        req      = 2'b01;
        keep_req = 2'b01;
        base     = done_total;
        for (guard = 0; guard < 4000 && done_total - base < 256; guard++) begin
            tick();
            if (m_done != 2'b00 && done_total - base == 255) check("wrap_255", xfer_count, 8'd255);
            if (m_done != 2'b00 && done_total - base == 256) check("wrap_0", xfer_count, 8'd0);
        end
        check("wrap_transfers", 8'(done_total - base), 8'(256));
        keep_req = 2'b00;
        req      = 2'b00;
        repeat (40) tick();

        $display("[TB] randomized traffic");
        random_mode = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 999) == 0) do_reset(1 + $urandom_range(0, 3));
            else tick();
        end
        random_mode = 1'b0;
        req         = 2'b00;
        repeat (60) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/slowlink_arbiter.md
SLOWLINK_ARBITER -- requirements
Module: slowlink_arbiter

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 3, giving the number of Bclk synchronizer flops (minimum 2).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum Aclk cycles to wait for a synchronized Bclk rise before flagging a stall.
REQ-003 The block SHALL have port Aclk, input, 1 bit: fast clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on Aclk.
REQ-005 The block SHALL have port Bclk, input, 1 bit: slow clock, asynchronous to Aclk, used only as data through the synchronizer.
REQ-006 The block SHALL have port req, input, 2 bits: per-requester transfer request, held high until the matching gnt bit pulses.
REQ-007 The block SHALL have ports data0 and data1, input, 4 bits each: requester payloads, stable while the matching req is high.
REQ-008 The block SHALL have port gnt, output, 2 bits: one-cycle pulse when the requester's data is loaded into hold_data.
REQ-009 The block SHALL have port done, output, 2 bits: one-cycle pulse when the slow domain has captured that requester's data.
REQ-010 The block SHALL have port hold_data, output, 4 bits: registered value driving the Bclk-domain sink register.
REQ-011 The block SHALL have port hold_valid, output, 1 bit: hold_data carries an uncaptured transfer.
REQ-012 The block SHALL have port hold_src, output, 1 bit: index of the requester owning hold_data.
REQ-013 The block SHALL have port xfer_count, output, 8 bits: completed transfers, wrapping 255 -> 0.
REQ-014 The block SHALL have port stall, output, 1 bit: sticky flag for a Bclk timeout.

Function
REQ-015 Bclk SHALL pass through SYNC_STAGES Aclk flops; bclk_s is the last stage, bclk_p is bclk_s delayed one cycle, and bclk_rise = bclk_s & ~bclk_p.
REQ-016 The state machine SHALL have exactly three states: IDLE, WAIT and HOLD.
REQ-017 IDLE: if req != 0, the next state SHALL be WAIT; otherwise it SHALL stay IDLE.
REQ-018 WAIT: on bclk_rise with req != 0, the block SHALL arbitrate and load (REQ-020), then go to HOLD.
REQ-019 WAIT: on bclk_rise with req == 0, the block SHALL return to IDLE with no gnt.
REQ-020 Load SHALL be a single Aclk edge that:
- copies the winner's data into hold_data;
- sets hold_src to the winner and hold_valid to 1;
- pulses gnt[winner] in the same cycle.
REQ-021 Arbitration SHALL be round-robin over the requests asserted in the bclk_rise cycle:
- a single request wins;
- with both requesting, the requester not granted last wins;
- after reset, requester 0 wins first.
REQ-022 HOLD: hold_data SHALL stay unchanged until the next bclk_rise.
REQ-023 HOLD, on bclk_rise:
- pulse done[hold_src] and increment xfer_count;
- if req != 0, perform a load in the same edge and stay in HOLD (back-to-back);
- otherwise clear hold_valid and go to IDLE.
REQ-024 On the done-only exit, hold_data and hold_src SHALL retain their last values.
REQ-025 hold_data SHALL change only on a bclk_rise edge, i.e. SYNC_STAGES to SYNC_STAGES+1 Aclk cycles after a Bclk rise, so it is stable at the next Bclk edge.
REQ-026 This guarantee SHALL hold provided Bclk high and low phases each last at least SYNC_STAGES+2 Aclk periods.
REQ-027 A wait counter SHALL clear on every bclk_rise and on entering WAIT, and count in WAIT/HOLD.
REQ-028 When the wait counter reaches TIMEOUT, stall SHALL set and stay set until reset; the FSM SHALL keep waiting.
REQ-029 A req bit dropping before grant SHALL be ignored; gnt and done SHALL never be high for both requesters in one cycle.

Reset
REQ-030 On reset, all outputs SHALL be 0, as SHALL the synchronizer flops and the wait counter.
REQ-031 On reset, the FSM SHALL enter IDLE and the round-robin pointer SHALL favour requester 0.
REQ-032 Reset mid-transfer SHALL abandon the transfer with no done pulse.

Verification
REQ-033 Single transfer: Bclk = Aclk/8, req=01, data0=A -> gnt=01 three Aclk cycles after a Bclk rise, hold_data=A, then done=01 and xfer_count=1 one Bclk period later.
REQ-034 Contention: req=11, data0=3, data1=C, held -> grants alternate 01,10,01; hold_data sequence 3,C,3 on consecutive Bclk rises; each done precedes or coincides with the next gnt.
REQ-035 Back-to-back: req0 held for 4 transfers -> hold_valid stays 1 throughout and hold_data changes only on bclk_rise edges.
REQ-036 Stall: Bclk held low with req=01, TIMEOUT=255 -> stall=1 at cycle 255 of waiting; Bclk restarted -> transfer completes and stall stays 1.
REQ-037 Reset mid-HOLD with hold_data=5 -> next cycle all outputs 0 and no done pulse; xfer_count wrap verified 255 -> 0 after 256 transfers.
